// File: rtl/sdram_rr_arbiter.sv
// sdram_rr_arbiter: round-robin Wishbone arbiter sharing one SDRAM controller port among four masters,
// with a per-grant burst cap and a stall watchdog.
module sdram_rr_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   m_cyc_i,
    input  logic [3:0]   m_stb_i,
    input  logic [3:0]   m_we_i,
    input  logic [15:0]  m_sel_i,
    input  logic [127:0] m_adr_i,
    input  logic [127:0] m_dat_i,
    output logic [3:0]   m_ack_o,
    output logic [3:0]   m_err_o,
    output logic [31:0]  m_dat_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic [3:0]   s_sel_o,
    output logic [31:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    input  logic         s_ack_i,
    input  logic [31:0]  s_dat_i,
    output logic [3:0]   grant_o
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t     r_state;
    logic [3:0] r_grant;
    logic [1:0] r_last;
    logic [7:0] r_beat;
    logic [9:0] r_wd;
    logic [3:0] r_err;
    logic [1:0] w_win;
    logic [1:0] w_cand;
    logic       w_own_cyc;
    logic       w_own_stb;
    logic       w_rel_a;
    logic       w_rel_b;
    logic       w_rel_c;

    assign w_own_cyc = |(m_cyc_i & r_grant);
    assign w_own_stb = |(m_stb_i & r_grant);
    assign w_rel_a   = !w_own_cyc;
    assign w_rel_b   = s_ack_i && (r_beat == 8'(MAX_BURST - 1));
    assign w_rel_c   = w_own_stb && !s_ack_i && (r_wd == 10'(TIMEOUT - 1));
    assign m_ack_o   = r_grant & {4{s_ack_i}};
    assign m_err_o   = r_err;
    assign m_dat_o   = s_dat_i;
    assign grant_o   = r_grant;

    // Walk from the lowest-priority slot (last itself) up to last+1 so the nearest requester wins.
    always_comb begin
        w_win  = r_last;
        w_cand = r_last;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_last + 2'(k);
            if (m_cyc_i[w_cand]) w_win = w_cand;
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_grant[i]) begin
                s_cyc_o = m_cyc_i[i];
                s_stb_o = m_stb_i[i];
                s_we_o  = m_we_i[i];
                s_sel_o = m_sel_i[4*i +: 4];
                s_adr_o = m_adr_i[32*i +: 32];
                s_dat_o = m_dat_i[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= 2'd3;
            r_beat  <= '0;
            r_wd    <= '0;
            r_err   <= '0;
        end else begin
            r_err <= '0;
            if (r_state == IDLE) begin
                if (|m_cyc_i) begin
                    r_state <= OWN;
                    r_grant <= 4'b0001 << w_win;
                    r_last  <= w_win;
                    r_beat  <= '0;
                    r_wd    <= '0;
                end
            end else if (w_rel_a || w_rel_b || w_rel_c) begin
                r_state <= IDLE;
                r_grant <= '0;
                // A terminal ack excludes a timeout, so only a cyc drop can mask the error.
                if (!w_rel_a && !w_rel_b) r_err <= r_grant;
            end else begin
                r_beat <= s_ack_i ? r_beat + 8'd1 : r_beat;
                r_wd   <= s_ack_i ? '0 : (w_own_stb ? r_wd + 10'd1 : r_wd);
            end
        end
    end
endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// tb_sdram_rr_arbiter: directed checks of rotation, burst cap, watchdog, tie cases, async reset and mux isolation.
module tb_sdram_rr_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   m_cyc_i = '0;
    logic [3:0]   m_stb_i = '0;
    logic [3:0]   m_we_i = '0;
    logic [15:0]  m_sel_i = '0;
    logic [127:0] m_adr_i = '0;
    logic [127:0] m_dat_i = '0;
    logic [3:0]   m_ack_o;
    logic [3:0]   m_err_o;
    logic [31:0]  m_dat_o;
    logic         s_cyc_o;
    logic         s_stb_o;
    logic         s_we_o;
    logic [3:0]   s_sel_o;
    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic         s_ack_i = 1'b0;
    logic [31:0]  s_dat_i = '0;
    logic [3:0]   grant_o;
    int errors = 0;
    int checks = 0;

    sdram_rr_arbiter #(.MAX_BURST(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i),
        .s_dat_i(s_dat_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
        m_adr_i = '0; m_dat_i = '0; s_ack_i = 1'b0; s_dat_i = '0;
        nxt;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m_cyc_i = 4'hF; m_stb_i = 4'hF; m_we_i = 4'hF; m_sel_i = '1;
        m_adr_i = '1; m_dat_i = '1; s_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc_o); end
        checks++; if (s_adr_o !== 32'h0) begin errors++; $display("FAIL reset_s_adr got=%h exp=0", s_adr_o); end
        checks++; if (m_ack_o !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", m_ack_o); end
        checks++; if (m_err_o !== 4'b0000) begin errors++; $display("FAIL reset_err got=%b exp=0000", m_err_o); end
        s_ack_i = 1'b0;
        rst = 1'b0;
        nxt;
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", grant_o); end
        do_reset;
    endtask

    task automatic test_fairness;
        logic [3:0] exp;
        m_cyc_i = 4'hF; m_stb_i = 4'hF;
        for (int n = 0; n < 8; n++) begin
            exp = 4'b0001 << (n % 4);
            nxt;
            checks++; if (grant_o !== exp || s_cyc_o !== 1'b1) begin errors++; $display("FAIL fair_grant n=%0d got=%b cyc=%b exp=%b", n, grant_o, s_cyc_o, exp); end
            nxt; s_ack_i = 1'b1; #1;
            checks++; if (m_ack_o !== exp) begin errors++; $display("FAIL fair_ack n=%0d got=%b exp=%b", n, m_ack_o, exp); end
            nxt; s_ack_i = 1'b0; m_cyc_i = m_cyc_i & ~exp; m_stb_i = m_stb_i & ~exp;
            nxt; m_cyc_i = m_cyc_i | exp; m_stb_i = m_stb_i | exp; #1;
            checks++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL fair_gap n=%0d got=%b cyc=%b exp=0000", n, grant_o, s_cyc_o); end
        end
        do_reset;
    endtask

    task automatic beats(input logic [3:0] own, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            nxt; s_ack_i = 1'b1; #1;
            checks++; if (m_ack_o !== own || grant_o !== own) begin errors++; $display("FAIL %s beat=%0d ack=%b grant=%b exp=%b", tag, i, m_ack_o, grant_o, own); end
        end
    endtask

    task automatic test_burst_cap;
        m_cyc_i = 4'b0110; m_stb_i = 4'b0110;
        beats(4'b0010, 8, "burst_fir1");
        nxt; s_ack_i = 1'b0; #1;
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL burst_gap1 got=%b exp=0000", grant_o); end
        nxt;
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL burst_qsort got=%b exp=0100", grant_o); end
        s_ack_i = 1'b1; m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0; #1;
        checks++; if (m_ack_o !== 4'b0100) begin errors++; $display("FAIL tie_ack_cycdrop got=%b exp=0100", m_ack_o); end
        nxt; s_ack_i = 1'b0; #1;
        checks++; if (grant_o !== 4'b0000 || m_ack_o !== 4'b0000) begin errors++; $display("FAIL tie_cycdrop_idle grant=%b ack=%b exp=0000", grant_o, m_ack_o); end
        beats(4'b0010, 8, "burst_fir2");
        nxt; s_ack_i = 1'b0; #1;
        checks++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL burst_gap2 grant=%b cyc=%b exp=0000", grant_o, s_cyc_o); end
        beats(4'b0010, 4, "burst_fir3");
        nxt; s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
        nxt;
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL burst_end got=%b exp=0000", grant_o); end
        do_reset;
    endtask

    task automatic test_watchdog;
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
        nxt;
        m_cyc_i = 4'b1001; m_stb_i = 4'b1001;
        checks++; if (grant_o !== 4'b1000) begin errors++; $display("FAIL wd_grant got=%b exp=1000", grant_o); end
        for (int k = 1; k < 64; k++) begin
            nxt;
            checks++; if (m_err_o !== 4'b0000 || grant_o !== 4'b1000) begin errors++; $display("FAIL wd_hold k=%0d err=%b grant=%b", k, m_err_o, grant_o); end
        end
        nxt;
        checks++; if (m_err_o !== 4'b1000) begin errors++; $display("FAIL wd_err got=%b exp=1000", m_err_o); end
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL wd_release got=%b exp=0000", grant_o); end
        nxt;
        checks++; if (m_err_o !== 4'b0000) begin errors++; $display("FAIL wd_err_pulse got=%b exp=0000", m_err_o); end
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL wd_next_cpu got=%b exp=0001", grant_o); end
        do_reset;
    endtask

    task automatic test_tie_terminal_wd;
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        beats(4'b0001, 7, "tie_pre");
        for (int i = 0; i < 63; i++) begin
            nxt; s_ack_i = 1'b0;
        end
        #1;
        checks++; if (grant_o !== 4'b0001 || m_err_o !== 4'b0000) begin errors++; $display("FAIL tie_stall grant=%b err=%b", grant_o, m_err_o); end
        nxt; s_ack_i = 1'b1; #1;
        checks++; if (m_ack_o !== 4'b0001) begin errors++; $display("FAIL tie_term_ack got=%b exp=0001", m_ack_o); end
        nxt; s_ack_i = 1'b0; #1;
        checks++; if (m_err_o !== 4'b0000) begin errors++; $display("FAIL tie_term_err got=%b exp=0000", m_err_o); end
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL tie_term_idle got=%b exp=0000", grant_o); end
        do_reset;
    endtask

    task automatic test_async_reset;
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001; m_we_i = 4'b0001;
        m_adr_i[31:0] = 32'h40; m_dat_i[31:0] = 32'h55AA55AA; m_sel_i[3:0] = 4'hF;
        beats(4'b0001, 3, "arst_beat");
        #2; rst = 1'b1; #1;
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL arst_s_cyc got=%b exp=0", s_cyc_o); end
        checks++; if (m_ack_o !== 4'b0000) begin errors++; $display("FAIL arst_ack got=%b exp=0000", m_ack_o); end
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL arst_grant got=%b exp=0000", grant_o); end
        nxt;
        rst = 1'b0; s_ack_i = 1'b0; m_cyc_i = 4'hF; m_stb_i = 4'hF;
        nxt;
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL arst_first got=%b exp=0001", grant_o); end
        do_reset;
    endtask

    task automatic test_mux_isolation;
        m_cyc_i = 4'hF; m_stb_i = 4'hF; m_we_i = 4'b0001;
        m_adr_i = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0100};
        m_dat_i = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
        m_sel_i = {4'hF, 4'hF, 4'hF, 4'h3};
        nxt;
        checks++; if (s_adr_o !== 32'h0000_0100) begin errors++; $display("FAIL mux_adr got=%h exp=00000100", s_adr_o); end
        checks++; if (s_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL mux_dat got=%h exp=12345678", s_dat_o); end
        checks++; if (s_sel_o !== 4'h3) begin errors++; $display("FAIL mux_sel got=%h exp=3", s_sel_o); end
        checks++; if (s_we_o !== 1'b1 || s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL mux_ctl we=%b stb=%b cyc=%b exp=111", s_we_o, s_stb_o, s_cyc_o); end
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D; #1;
        checks++; if (m_ack_o !== 4'b0001) begin errors++; $display("FAIL mux_ack got=%b exp=0001", m_ack_o); end
        checks++; if (m_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL mux_rdata got=%h exp=cafef00d", m_dat_o); end
        nxt;
        s_ack_i = 1'b0; m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; m_we_i = 4'b0010;
        m_adr_i[63:32] = 32'h0000_0200; m_dat_i[63:32] = 32'h2222_3333; m_sel_i[7:4] = 4'hC;
        nxt; s_dat_i = 32'h0BAD_F00D; #1;
        checks++; if (s_cyc_o !== 1'b0 || s_adr_o !== 32'h0) begin errors++; $display("FAIL mux_idle cyc=%b adr=%h exp=0", s_cyc_o, s_adr_o); end
        checks++; if (m_dat_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL mux_idle_rdata got=%h exp=0badf00d", m_dat_o); end
        nxt;
        checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL mux_fir_grant got=%b exp=0010", grant_o); end
        checks++; if (s_adr_o !== 32'h0000_0200 || s_dat_o !== 32'h2222_3333 || s_sel_o !== 4'hC || s_we_o !== 1'b1) begin
            errors++; $display("FAIL mux_fir adr=%h dat=%h sel=%h we=%b", s_adr_o, s_dat_o, s_sel_o, s_we_o);
        end
        do_reset;
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_burst_cap;
        test_watchdog;
        test_tie_terminal_wd;
        test_async_reset;
        test_mux_isolation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
